// File: rtl/i_fetch_queue_pkg.sv
// Shared fetch types: queue entry layout, fetch FSM states and the default boot PC.
package i_fetch_queue_pkg;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h4000_0000;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] pc_next;
    logic [31:0] instr;
  } fetch_entry_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    DROP = 2'd2
  } fetch_state_t;

endpackage

// File: rtl/i_fetch_queue_fifo.sv
// Circular QDEPTH-entry buffer of fetched {pc, pc_next, instr}; head is a plain register read.
module i_fetch_queue_fifo
  import i_fetch_queue_pkg::*;
#(
  parameter int QDEPTH = 4,
  localparam int PW = $clog2(QDEPTH),
  localparam int CW = PW + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push_i,
  input  fetch_entry_t  push_data_i,
  input  logic          pop_i,
  input  logic          flush_i,
  output fetch_entry_t  head_o,
  output logic          full_o,
  output logic          empty_o,
  output logic [CW-1:0] count_o
);

  logic [PW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CW-1:0] count_q;
  fetch_entry_t  mem_q [QDEPTH];

  // Storage is cleared on reset so the head outputs read zero while rst is low.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < QDEPTH; i++) mem_q[i] <= '0;
    end else if (flush_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_i) begin
        mem_q[wr_ptr_q] <= push_data_i;
        wr_ptr_q        <= wr_ptr_q + 1'b1;
      end
      if (pop_i) rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q <= count_q + CW'(push_i) - CW'(pop_i);
    end
  end

  assign head_o  = mem_q[rd_ptr_q];
  assign full_o  = (count_q == CW'(QDEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;

endmodule

// File: rtl/i_fetch_queue.sv
// Decoupled instruction fetch: single-outstanding cache request engine feeding a prefetch FIFO.
module i_fetch_queue
  import i_fetch_queue_pkg::*;
#(
  parameter int          QDEPTH   = 4,
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        redirect,
  input  logic [31:0] redirect_target,
  input  logic        redirect_mod2,
  output logic        imem_read,
  output logic [31:0] imem_address,
  input  logic [31:0] imem_rdata,
  input  logic        imem_resp,
  output logic        if_valid,
  input  logic        if_ready,
  output logic [31:0] if_pc,
  output logic [31:0] if_pc_next,
  output logic [31:0] if_instr
);

  localparam int CW = $clog2(QDEPTH) + 1;

  fetch_state_t  state_q, state_d;
  logic [31:0]   fetch_pc_q, fetch_pc_d;
  logic [31:0]   addr_q, addr_d;
  logic          push, pop;
  logic          fifo_full, fifo_empty;
  logic [CW-1:0] fifo_count, count_after;
  fetch_entry_t  push_data, head;

  // Redirect wins over both a same-cycle push and pop; the flush empties the queue anyway.
  assign push        = (state_q == REQ) && imem_resp && !redirect;
  assign pop         = !fifo_empty && if_ready && !redirect;
  assign count_after = fifo_count + CW'(push) - CW'(pop);
  assign push_data   = '{pc: addr_q, pc_next: addr_q + 32'd4, instr: imem_rdata};

  always_comb begin
    fetch_pc_d = fetch_pc_q;
    if (redirect)  fetch_pc_d = {redirect_target[31:1], redirect_target[0] & ~redirect_mod2};
    else if (push) fetch_pc_d = fetch_pc_q + 32'd4;

    state_d = state_q;
    case (state_q)
      IDLE: if (!redirect && !fifo_full) state_d = REQ;
      REQ: begin
        if (redirect)       state_d = imem_resp ? REQ : DROP;
        else if (imem_resp) state_d = (count_after < CW'(QDEPTH)) ? REQ : IDLE;
      end
      DROP: if (imem_resp) state_d = REQ;
      default: state_d = IDLE;
    endcase

    // A request in flight is never withdrawn: DROP keeps presenting the stale address.
    addr_d = (state_d == DROP) ? addr_q : fetch_pc_d;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      fetch_pc_q <= RESET_PC;
      addr_q     <= '0;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      addr_q     <= addr_d;
    end
  end

  i_fetch_queue_fifo #(.QDEPTH(QDEPTH)) u_fifo (
    .clk        (clk),
    .rst        (rst),
    .push_i     (push),
    .push_data_i(push_data),
    .pop_i      (pop),
    .flush_i    (redirect),
    .head_o     (head),
    .full_o     (fifo_full),
    .empty_o    (fifo_empty),
    .count_o    (fifo_count)
  );

  assign imem_read    = (state_q != IDLE);
  assign imem_address = addr_q;
  assign if_valid     = !fifo_empty;
  assign if_pc        = head.pc;
  assign if_pc_next   = head.pc_next;
  assign if_instr     = head.instr;

endmodule
